timer_bank: RTL and testbench

//   Multi-channel, CSR-mapped peripheral timer; parametrised successor of the single TimerAddr timer.

---
 rtl/timer_bank_if.sv | 20 ++
 rtl/timer_bank.sv | 94 +++++++++
 tb/tb_timer_bank.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_if.sv
// CSR bus bundle for the timer bank: access strobe, address,
// write data and the block's combinational read data / decode hit.
interface timer_bank_if;
   logic        enable;
   logic [11:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;

   modport master (
      output enable, addr, we, wdata,
      input  rdata, hit
   );

   modport slave (
      input  enable, addr, we, wdata,
      output rdata, hit
   );
endinterface

// File: rtl/timer_bank.sv
// Multi-channel CSR-mapped timer: per-channel top/prescaler/enable/one-shot,
// one-cycle expiry pulse per channel, live count readable over CSR.
module timer_bank #(
   parameter int          NumCh    = 4,
   parameter int          Width    = 16,
   parameter int          PreWidth = 4,
   parameter logic [11:0] Base     = 12'h400
) (
   input  logic             clk,
   input  logic             reset,
   timer_bank_if.slave      csr,
   output logic [NumCh-1:0] irq
);
   localparam int CW   = Width + 2**PreWidth;
   localparam int CfgW = PreWidth + Width + 2;
   localparam int RW   = (CW < 32) ? CW : 32;
   localparam int ChW  = (NumCh > 1) ? $clog2(NumCh) : 1;
   localparam logic [11:0] Span = 12'(2 * NumCh);

   logic [PreWidth-1:0] pre [NumCh];
   logic [Width-1:0]    top [NumCh];
   logic [CW-1:0]       cnt [NumCh];
   logic [CW-1:0]       cmp [NumCh];
   logic [NumCh-1:0]    en;
   logic [NumCh-1:0]    os;
   logic [NumCh-1:0]    wr_ch;
   logic [NumCh-1:0]    expire;

   logic [11:0]    off;
   logic [ChW-1:0] sel;
   logic           is_cnt;
   logic           wr;
   logic           unused;

   // Offset wraps for addresses below Base, so one compare covers both ends.
   assign off     = csr.addr - Base;
   assign csr.hit = off < Span;
   assign sel     = off[ChW:1];
   assign is_cnt  = off[0];
   assign wr      = csr.enable & csr.we & csr.hit & ~is_cnt;
   assign unused  = ^{off[11:ChW+1], csr.wdata[31:CfgW]};

   always_comb begin
      csr.rdata = '0;
      if (csr.hit) begin
         if (is_cnt)
            csr.rdata[RW-1:0] = cnt[sel][RW-1:0];
         else
            csr.rdata[CfgW-1:0] = {os[sel], en[sel], top[sel], pre[sel]};
      end
   end

   always_comb begin
      wr_ch  = '0;
      expire = '0;
      for (int c = 0; c < NumCh; c++) begin
         cmp[c]    = CW'(top[c]) << pre[c];
         wr_ch[c]  = wr && (sel == ChW'(c));
         expire[c] = !wr_ch[c] && en[c] && (cnt[c] == cmp[c]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en  <= '0;
         os  <= '0;
         irq <= '0;
         for (int c = 0; c < NumCh; c++) begin
            pre[c] <= '0;
            top[c] <= '0;
            cnt[c] <= '0;
         end
      end else begin
         irq <= expire;
         for (int c = 0; c < NumCh; c++) begin
            if (wr_ch[c]) begin
               pre[c] <= csr.wdata[PreWidth-1:0];
               top[c] <= csr.wdata[PreWidth +: Width];
               en[c]  <= csr.wdata[PreWidth+Width];
               os[c]  <= csr.wdata[PreWidth+Width+1];
               cnt[c] <= '0;
            end else if (!en[c]) begin
               cnt[c] <= '0;
            end else if (expire[c]) begin
               cnt[c] <= '0;
               if (os[c])
                  en[c] <= 1'b0;
            end else begin
               cnt[c] <= cnt[c] + CW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: cycle model feeds an irq scoreboard,
// directed CSR reads check timing, decode and reset behaviour.
module tb_timer_bank;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] irq;

   timer_bank_if bus ();

   timer_bank #(
      .NumCh(4), .Width(16), .PreWidth(4), .Base(12'h400)
   ) dut (
      .clk(clk),
      .reset(rst_n),
      .csr(bus.slave),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [3:0]  irq_q [$];
   logic [31:0] rd_q [$];

   logic [3:0]  m_pre [4];
   logic [15:0] m_top [4];
   logic [31:0] m_cnt [4];
   logic [31:0] m_cmp [4];
   logic [3:0]  m_en, m_os, m_wr, m_exp;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cfg(int t, int p, bit e, bit o);
      return {10'b0, o, e, 16'(t), 4'(p)};
   endfunction

   function automatic logic [11:0] cfg_a(int c);
      return 12'h400 + 12'(2 * c);
   endfunction

   function automatic logic [11:0] cnt_a(int c);
      return 12'h401 + 12'(2 * c);
   endfunction

   always_comb begin
      m_wr  = '0;
      m_exp = '0;
      for (int c = 0; c < 4; c++) begin
         m_wr[c]  = bus.enable && bus.we && (bus.addr == cfg_a(c));
         m_cmp[c] = 32'(m_top[c]) << m_pre[c];
         m_exp[c] = !m_wr[c] && m_en[c] && (m_cnt[c] == m_cmp[c]);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_en <= '0;
         m_os <= '0;
         for (int c = 0; c < 4; c++) begin
            m_pre[c] <= '0;
            m_top[c] <= '0;
            m_cnt[c] <= '0;
         end
         irq_q.delete();
      end else begin
         irq_q.push_back(m_exp);
         for (int c = 0; c < 4; c++) begin
            if (m_wr[c]) begin
               m_pre[c] <= bus.wdata[3:0];
               m_top[c] <= bus.wdata[19:4];
               m_en[c]  <= bus.wdata[20];
               m_os[c]  <= bus.wdata[21];
               m_cnt[c] <= '0;
            end else if (!m_en[c] || m_exp[c]) begin
               m_cnt[c] <= '0;
               if (m_exp[c] && m_os[c])
                  m_en[c] <= 1'b0;
            end else begin
               m_cnt[c] <= m_cnt[c] + 32'd1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && irq_q.size() > 0)
         check("irq_sb", 32'(irq), 32'(irq_q.pop_front()));
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      bus.enable = 1'b1;
      bus.we     = 1'b1;
      bus.addr   = a;
      bus.wdata  = d;
      @(negedge clk);
      bus.enable = 1'b0;
      bus.we     = 1'b0;
   endtask

   task automatic csr_rd(input string tag, input logic [11:0] a,
                         input logic [31:0] exp);
      bus.addr = a;
      rd_q.push_back(exp);
      #1;
      check(tag, bus.rdata, rd_q.pop_front());
   endtask

   task automatic wait_irq(input int ch, input int lim, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!irq[ch] && n < lim);
   endtask

   int n;

   initial begin
      bus.enable = 1'b0;
      bus.we     = 1'b0;
      bus.addr   = '0;
      bus.wdata  = '0;

      // Reset held: writes must not land
      cyc(1);
      csr_wr(cfg_a(0), cfg(0, 0, 1, 0));
      csr_rd("rst_cfg0", cfg_a(0), 32'h0);
      csr_rd("rst_cnt0", cnt_a(0), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      check("post_rst_irq", 32'(irq), 32'h0);

      // Periodic: top=3 pre=1 -> cmp=6, period 7
      csr_wr(cfg_a(0), cfg(3, 1, 1, 0));
      for (int i = 0; i < 7; i++) begin
         csr_rd($sformatf("per_cnt%0d", i), cnt_a(0), 32'(i));
         check("per_noirq", 32'(irq[0]), 32'h0);
         cyc(1);
      end
      check("per_irq1", 32'(irq[0]), 32'h1);
      csr_rd("per_cnt_wrap", cnt_a(0), 32'h0);
      wait_irq(0, 20, n);
      check("per_period", 32'(n), 32'd7);
      cyc(1);
      check("per_pulse_w", 32'(irq[0]), 32'h0);
      csr_wr(cfg_a(0), 32'h0);

      // One-shot: top=2 pre=0
      csr_wr(cfg_a(1), cfg(2, 0, 1, 1));
      wait_irq(1, 20, n);
      check("os_delay", 32'(n), 32'd3);
      cyc(1);
      check("os_irq_low", 32'(irq[1]), 32'h0);
      csr_rd("os_cfg_en", cfg_a(1), cfg(2, 0, 0, 1));
      csr_rd("os_cnt", cnt_a(1), 32'h0);
      cyc(5);
      check("os_no_rearm", 32'(irq[1]), 32'h0);
      csr_rd("os_cnt_late", cnt_a(1), 32'h0);

      // Write collision at cnt==cmp
      csr_wr(cfg_a(0), cfg(3, 0, 1, 0));
      cyc(3);
      csr_rd("col_at_cmp", cnt_a(0), 32'd3);
      csr_wr(cfg_a(0), cfg(3, 0, 1, 0));
      check("col_no_irq", 32'(irq[0]), 32'h0);
      csr_rd("col_cnt0", cnt_a(0), 32'h0);
      wait_irq(0, 20, n);
      check("col_restart", 32'(n), 32'd4);
      csr_wr(cfg_a(0), 32'h0);

      // CNT write ignored while running
      csr_wr(cfg_a(2), cfg(5, 0, 1, 0));
      cyc(2);
      csr_wr(cnt_a(2), 32'h0);
      csr_rd("cntwr_cnt", cnt_a(2), 32'd3);
      csr_rd("cntwr_cfg", cfg_a(2), cfg(5, 0, 1, 0));
      csr_wr(cfg_a(2), 32'h0);

      // Decode edges
      csr_rd("dec_out_rd", 12'h408, 32'h0);
      check("dec_out_hit", 32'(bus.hit), 32'h0);
      csr_rd("dec_low_rd", 12'h3ff, 32'h0);
      check("dec_low_hit", 32'(bus.hit), 32'h0);
      csr_rd("dec_last_rd", cnt_a(3), 32'h0);
      check("dec_last_hit", 32'(bus.hit), 32'h1);
      csr_wr(cfg_a(3), 32'hffff_ffff);
      csr_rd("dec_mask", cfg_a(3), 32'h003f_ffff);
      csr_wr(cfg_a(3), 32'h0);

      // Equal CFG on ch0/ch2, top=0 pre=0 -> both held high
      csr_wr(cfg_a(0), cfg(0, 0, 1, 0));
      csr_wr(cfg_a(2), cfg(0, 0, 1, 0));
      cyc(1);
      for (int i = 0; i < 3; i++) begin
         check("coinc", 32'(irq), 32'h5);
         cyc(1);
      end
      csr_wr(cfg_a(0), 32'h0);
      csr_wr(cfg_a(2), 32'h0);

      // Max prescaler: top=2 pre=15 -> cmp=65536
      csr_wr(cfg_a(0), cfg(2, 15, 1, 0));
      cyc(65536);
      csr_rd("max_cnt", cnt_a(0), 32'h0001_0000);
      check("max_noirq", 32'(irq[0]), 32'h0);
      cyc(1);
      check("max_irq", 32'(irq[0]), 32'h1);
      csr_rd("max_wrap", cnt_a(0), 32'h0);

      // Asynchronous reset mid-count with irq held high
      csr_wr(cfg_a(2), cfg(0, 0, 1, 0));
      cyc(2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_irq", 32'(irq), 32'h0);
      csr_rd("arst_cfg2", cfg_a(2), 32'h0);
      csr_rd("arst_cnt0", cnt_a(0), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(3);
      check("arst_rel_irq", 32'(irq), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
